// File: rtl/flappy_physics.sv
// Bird physics: signed velocity, gravity, flap impulse, terminal fall,
// ceiling clamp, floor death and a self-generated physics tick.
module flappy_physics #(
  parameter int SCREEN_H  = 480,
  parameter int BIRD_SIZE = 15,
  parameter int START_X   = 160,
  parameter int START_Y   = 240,
  parameter int TICK_DIV  = 4166666,
  parameter int GRAVITY   = 2,
  parameter int FLAP_VEL  = 12,
  parameter int MAX_FALL  = 16,
  parameter int VW        = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 flap,
  output logic [9:0]           x0,
  output logic [8:0]           y0,
  output logic signed [VW-1:0] vel,
  output logic                 dead,
  output logic                 hit_floor
);

  localparam int Y_MAX = SCREEN_H - BIRD_SIZE;
  localparam int CW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [8:0]           SPAWN_Y   = 9'(START_Y);
  localparam logic [8:0]           FLOOR_Y   = 9'(Y_MAX);
  localparam logic signed [10:0]   FLOOR_N   = 11'(Y_MAX);
  localparam logic [CW-1:0]        TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic signed [VW-1:0] FLAP_V    = VW'(-FLAP_VEL);
  localparam logic signed [VW:0]   GRAV_V    = (VW+1)'(GRAVITY);
  localparam logic signed [VW:0]   FALL_V    = (VW+1)'(MAX_FALL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DEAD
  } state_t;

  state_t                 r_state;
  state_t                 w_nstate;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_ncnt;
  logic                   r_flap_q;
  logic [8:0]             r_y0;
  logic [8:0]             w_ny0;
  logic signed [VW-1:0]   r_vel;
  logic signed [VW-1:0]   w_nvel;
  logic                   r_dead;
  logic                   r_hit;
  logic                   w_nhit;
  logic                   w_fe;
  logic                   w_tick;
  logic signed [10:0]     w_ny;
  logic signed [VW:0]     w_vsum;
  logic signed [VW-1:0]   w_vgrav;

  assign w_fe   = flap & ~r_flap_q;
  assign w_tick = (r_state == S_RUN) && (r_cnt == TICK_LAST);
  assign w_ny   = $signed({2'b00, r_y0})
                + $signed({{(11-VW){r_vel[VW-1]}}, r_vel});
  assign w_vsum = $signed({r_vel[VW-1], r_vel}) + GRAV_V;
  assign w_vgrav = (w_vsum > FALL_V) ? FALL_V[VW-1:0]
                                     : w_vsum[VW-1:0];

  assign x0        = 10'(START_X);
  assign y0        = r_y0;
  assign vel       = r_vel;
  assign dead      = r_dead;
  assign hit_floor = r_hit;

  // Next-state and next-value decode for the IDLE/RUN/DEAD machine
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = '0;
    w_ny0    = r_y0;
    w_nvel   = r_vel;
    w_nhit   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ny0  = SPAWN_Y;
        w_nvel = '0;
        if (start) w_nstate = S_RUN;
      end
      S_RUN: begin
        if (!start) begin
          w_nstate = S_IDLE;
          w_ny0    = SPAWN_Y;
          w_nvel   = '0;
        end else if (w_tick) begin
          if (w_ny >= FLOOR_N) begin
            w_nstate = S_DEAD;
            w_ny0    = FLOOR_Y;
            w_nvel   = '0;
            w_nhit   = 1'b1;
          end else if (w_ny[10]) begin
            w_ny0  = '0;
            w_nvel = w_fe ? FLAP_V : '0;
          end else begin
            w_ny0  = w_ny[8:0];
            w_nvel = w_fe ? FLAP_V : w_vgrav;
          end
        end else begin
          w_ncnt = r_cnt + CW'(1);
          if (w_fe) w_nvel = FLAP_V;
        end
      end
      S_DEAD: begin
        w_ny0  = FLOOR_Y;
        w_nvel = '0;
        if (!start) begin
          w_nstate = S_IDLE;
          w_ny0    = SPAWN_Y;
        end
      end
      default: begin
        w_nstate = S_IDLE;
        w_ny0    = SPAWN_Y;
        w_nvel   = '0;
      end
    endcase
  end

  // State, tick counter, flap delay and bird registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_flap_q <= 1'b0;
      r_y0     <= SPAWN_Y;
      r_vel    <= '0;
      r_dead   <= 1'b0;
      r_hit    <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_cnt    <= w_ncnt;
      r_flap_q <= flap;
      r_y0     <= w_ny0;
      r_vel    <= w_nvel;
      r_dead   <= (w_nstate == S_DEAD);
      r_hit    <= w_nhit;
    end
  end

endmodule

// File: tb/tb_flappy_physics.sv
// Bench for flappy_physics with TICK_DIV = 4: vector table plus
// hand-built corner sequences, checked through an expectation queue.
module tb_flappy_physics;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              flap = 1'b0;
  logic [9:0]        x0;
  logic [8:0]        y0;
  logic signed [7:0] vel;
  logic              dead;
  logic              hit_floor;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic  rst_n;
    logic  st;
    logic  fl;
    int    n;
    int    y;
    int    v;
    logic  d;
    logic  h;
    string name;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  flappy_physics #(.TICK_DIV(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .flap      (flap),
    .x0        (x0),
    .y0        (y0),
    .vel       (vel),
    .dead      (dead),
    .hit_floor (hit_floor)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic r, input logic s, input logic f, input int n,
    input int y, input int v, input logic d, input logic h,
    input string nm);
    vec_t e;
    e.rst_n = r; e.st = s; e.fl = f; e.n = n;
    e.y = y; e.v = v; e.d = d; e.h = h; e.name = nm;
    return e;
  endfunction

  task automatic check_out();
    vec_t e;
    e = exp_q.pop_front();
    n_tests++;
    if (int'(y0) != e.y || int'($signed(vel)) != e.v ||
        dead !== e.d || hit_floor !== e.h || int'(x0) != 160) begin
      n_fail++;
      $display("FAIL %s: got y0=%0d vel=%0d dead=%b hit=%b x0=%0d, want y0=%0d vel=%0d dead=%b hit=%b x0=160",
               e.name, y0, $signed(vel), dead, hit_floor, x0,
               e.y, e.v, e.d, e.h);
    end
  endtask

  task automatic step(input vec_t e);
    exp_q.push_back(e);
    reset_n = e.rst_n;
    start   = e.st;
    flap    = e.fl;
    repeat (e.n) @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    tbl.push_back(mk(0,0,0,2, 240,  0,0,0,"reset"));
    tbl.push_back(mk(1,0,0,3, 240,  0,0,0,"idle_hold"));
    tbl.push_back(mk(1,1,0,1, 240,  0,0,0,"enter_run"));
    tbl.push_back(mk(1,1,0,3, 240,  0,0,0,"no_tick_yet"));
    tbl.push_back(mk(1,1,0,1, 240,  2,0,0,"fall_t1"));
    tbl.push_back(mk(1,1,0,4, 242,  4,0,0,"fall_t2"));
    tbl.push_back(mk(1,1,0,4, 246,  6,0,0,"fall_t3"));
    tbl.push_back(mk(1,1,0,4, 252,  8,0,0,"fall_t4"));
    tbl.push_back(mk(1,1,0,4, 260, 10,0,0,"fall_t5"));
    tbl.push_back(mk(1,1,0,4, 270, 12,0,0,"fall_t6"));
    tbl.push_back(mk(1,1,0,4, 282, 14,0,0,"fall_t7"));
    tbl.push_back(mk(1,1,0,4, 296, 16,0,0,"fall_t8"));
    tbl.push_back(mk(1,1,0,4, 312, 16,0,0,"term_t9"));
    tbl.push_back(mk(1,1,0,4, 328, 16,0,0,"term_t10"));
    tbl.push_back(mk(1,1,0,4, 344, 16,0,0,"term_t11"));
    tbl.push_back(mk(1,1,0,4, 360, 16,0,0,"term_t12"));
    tbl.push_back(mk(1,1,0,4, 376, 16,0,0,"term_t13"));
    tbl.push_back(mk(1,1,0,4, 392, 16,0,0,"term_t14"));
    tbl.push_back(mk(1,1,0,4, 408, 16,0,0,"term_t15"));
    tbl.push_back(mk(1,1,0,4, 424, 16,0,0,"term_t16"));
    tbl.push_back(mk(1,1,0,4, 440, 16,0,0,"term_t17"));
    tbl.push_back(mk(1,1,0,4, 456, 16,0,0,"term_t18"));
    tbl.push_back(mk(1,1,0,3, 456, 16,0,0,"pre_floor"));
    tbl.push_back(mk(1,1,0,1, 465,  0,1,1,"floor_hit"));
    tbl.push_back(mk(1,1,0,1, 465,  0,1,0,"hit_one_cycle"));
    tbl.push_back(mk(1,1,1,4, 465,  0,1,0,"dead_hold"));
    tbl.push_back(mk(1,0,0,1, 240,  0,0,0,"dead_to_idle"));
    tbl.push_back(mk(1,1,0,1, 240,  0,0,0,"run2"));
    tbl.push_back(mk(1,1,0,4, 240,  2,0,0,"f_t1"));
    tbl.push_back(mk(1,1,0,4, 242,  4,0,0,"f_t2"));
    tbl.push_back(mk(1,1,0,4, 246,  6,0,0,"f_t3"));
    tbl.push_back(mk(1,1,1,1, 246,-12,0,0,"flap_vel"));
    tbl.push_back(mk(1,1,0,3, 234,-10,0,0,"flap_t1"));
    tbl.push_back(mk(1,1,0,4, 224, -8,0,0,"flap_t2"));
    tbl.push_back(mk(1,0,0,1, 240,  0,0,0,"run_to_idle"));
    tbl.push_back(mk(1,1,0,1, 240,  0,0,0,"run3"));
    tbl.push_back(mk(1,1,0,4, 240,  2,0,0,"s_t1"));
    tbl.push_back(mk(1,1,0,4, 242,  4,0,0,"s_t2"));
    tbl.push_back(mk(1,1,0,4, 246,  6,0,0,"s_t3"));
    tbl.push_back(mk(1,1,0,4, 252,  8,0,0,"s_t4"));
    tbl.push_back(mk(1,1,0,3, 252,  8,0,0,"s_pre"));
    tbl.push_back(mk(1,1,1,1, 260,-12,0,0,"flap_on_tick"));
    tbl.push_back(mk(1,1,0,4, 248,-10,0,0,"after_ftick"));

    foreach (tbl[i]) step(tbl[i]);

    // ceiling: climb to y0=6 with vel=-12, then overshoot above 0
    step(mk(1,0,0,1, 240,  0,0,0,"c_idle"));
    step(mk(1,1,0,1, 240,  0,0,0,"c_run"));
    step(mk(1,1,1,1, 240,-12,0,0,"c_flap"));
    step(mk(1,1,0,3, 228,-10,0,0,"c_t1"));
    step(mk(1,1,0,4, 218, -8,0,0,"c_t2"));
    step(mk(1,1,0,3, 218, -8,0,0,"c_pre"));
    step(mk(1,1,1,1, 210,-12,0,0,"c_t3"));
    for (int k = 1; k <= 17; k++) begin
      step(mk(1,1,0,3, 210 - 12*(k-1),-12,0,0,"c_climb_pre"));
      step(mk(1,1,1,1, 210 - 12*k,    -12,0,0,"c_climb"));
    end
    step(mk(1,1,0,4,   0,  0,0,0,"ceil_clamp"));
    step(mk(1,1,0,4,   0,  2,0,0,"ceil_next"));

    // reset mid-run, then counter restarts from zero
    step(mk(0,1,0,1, 240,  0,0,0,"mid_reset"));
    step(mk(1,1,0,1, 240,  0,0,0,"rr_run"));
    step(mk(1,1,0,3, 240,  0,0,0,"rr_no_tick"));
    step(mk(1,1,0,1, 240,  2,0,0,"rr_tick"));

    // flap held through the start rise gives no impulse
    step(mk(1,0,1,3, 240,  0,0,0,"h_idle"));
    step(mk(1,1,1,1, 240,  0,0,0,"h_run"));
    step(mk(1,1,1,3, 240,  0,0,0,"h_no_flap"));
    step(mk(1,1,1,1, 240,  2,0,0,"h_gravity"));

    // flap edge on the floor-hit tick still dies
    step(mk(1,0,0,1, 240,  0,0,0,"ff_idle"));
    step(mk(1,1,0,1, 240,  0,0,0,"ff_run"));
    step(mk(1,1,0,72,456, 16,0,0,"ff_fall"));
    step(mk(1,1,0,3, 456, 16,0,0,"ff_pre"));
    step(mk(1,1,1,1, 465,  0,1,1,"ff_floor_flap"));
    step(mk(1,1,0,1, 465,  0,1,0,"ff_dead"));
    step(mk(1,0,0,1, 240,  0,0,0,"ff_idle2"));

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard: %0d left, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
